// File: rtl/ex_cnt.sv
// ex_cnt: free-running modulo-(MAX_VAL+1) up-counter with terminal-count strobe,
// half-period flag and a saturating count of completed wraps.
`default_nettype none

module ex_cnt #(
  parameter int          WIDTH   = 10,
  parameter int unsigned MAX_VAL = 1023,
  parameter int          WRAP_W  = 8
) (
  input  logic              sclk,
  input  logic              rst,
  output logic [WIDTH-1:0]  cnt,
  output logic              cnt_tc,
  output logic              cnt_half,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [WIDTH-1:0]  c_MAX      = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0]  c_HALF     = WIDTH'(MAX_VAL / 2);
  localparam logic [WRAP_W-1:0] c_WRAP_SAT = '1;

  logic [WIDTH-1:0]  r_cnt;
  logic              r_tc;
  logic              r_half;
  logic [WRAP_W-1:0] r_wrap;

  logic              w_at_max;
  logic [WIDTH-1:0]  w_cnt_nxt;

  always_comb begin
    w_at_max  = (r_cnt == c_MAX);
    w_cnt_nxt = w_at_max ? '0 : r_cnt + WIDTH'(1);
  end

  // Flags are derived from the next count so they line up with cnt, not lag it.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tc   <= 1'b0;
      r_half <= 1'b0;
      r_wrap <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tc   <= (w_cnt_nxt == c_MAX);
      r_half <= (w_cnt_nxt > c_HALF);
      if (w_at_max && (r_wrap != c_WRAP_SAT)) begin
        r_wrap <= r_wrap + WRAP_W'(1);
      end
    end
  end

  assign cnt      = r_cnt;
  assign cnt_tc   = r_tc;
  assign cnt_half = r_half;
  assign wrap_cnt = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_ex_cnt.sv
// tb_ex_cnt: directed table-driven check of ex_cnt with default parameters and
// with MAX_VAL=9 / WRAP_W=2, plus mid-count and coincident-reset sequences.
`timescale 1ns/100ps
`default_nettype none

module tb_ex_cnt;

  logic       sclk;
  logic       rst_a;
  logic       rst_b;
  logic [9:0] a_cnt;
  logic       a_tc;
  logic       a_half;
  logic [7:0] a_wrap;
  logic [9:0] b_cnt;
  logic       b_tc;
  logic       b_half;
  logic [1:0] b_wrap;

  int n_checks;
  int n_fails;

  ex_cnt u_dut_a (
    .sclk     (sclk),
    .rst      (rst_a),
    .cnt      (a_cnt),
    .cnt_tc   (a_tc),
    .cnt_half (a_half),
    .wrap_cnt (a_wrap)
  );

  ex_cnt #(
    .WIDTH   (10),
    .MAX_VAL (9),
    .WRAP_W  (2)
  ) u_dut_b (
    .sclk     (sclk),
    .rst      (rst_b),
    .cnt      (b_cnt),
    .cnt_tc   (b_tc),
    .cnt_half (b_half),
    .wrap_cnt (b_wrap)
  );

  initial sclk = 1'b0;
  always #10 sclk = ~sclk;

  typedef struct {
    int         k;
    logic [9:0] a_cnt;
    logic       a_tc;
    logic       a_half;
    logic [7:0] a_wrap;
    logic [9:0] b_cnt;
    logic       b_tc;
    logic       b_half;
    logic [1:0] b_wrap;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic chk_a(input string tag, input logic [9:0] c, input logic tc,
                       input logic h, input logic [7:0] w);
    chk({tag, " a.cnt"},      32'(a_cnt),  32'(c));
    chk({tag, " a.cnt_tc"},   32'(a_tc),   32'(tc));
    chk({tag, " a.cnt_half"}, 32'(a_half), 32'(h));
    chk({tag, " a.wrap_cnt"}, 32'(a_wrap), 32'(w));
  endtask

  task automatic chk_b(input string tag, input logic [9:0] c, input logic tc,
                       input logic h, input logic [1:0] w);
    chk({tag, " b.cnt"},      32'(b_cnt),  32'(c));
    chk({tag, " b.cnt_tc"},   32'(b_tc),   32'(tc));
    chk({tag, " b.cnt_half"}, 32'(b_half), 32'(h));
    chk({tag, " b.wrap_cnt"}, 32'(b_wrap), 32'(w));
  endtask

  initial begin
    int cur;
    n_checks = 0;
    n_fails  = 0;

    // k = edges sampled with rst=0; A: MAX 1023, half >511. B: MAX 9, half >4, wrap sat 3.
    tbl.push_back('{0,    10'd0,    1'b0, 1'b0, 8'd0, 10'd0, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{1,    10'd1,    1'b0, 1'b0, 8'd0, 10'd1, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{4,    10'd4,    1'b0, 1'b0, 8'd0, 10'd4, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{5,    10'd5,    1'b0, 1'b0, 8'd0, 10'd5, 1'b0, 1'b1, 2'd0});
    tbl.push_back('{9,    10'd9,    1'b0, 1'b0, 8'd0, 10'd9, 1'b1, 1'b1, 2'd0});
    tbl.push_back('{10,   10'd10,   1'b0, 1'b0, 8'd0, 10'd0, 1'b0, 1'b0, 2'd1});
    tbl.push_back('{19,   10'd19,   1'b0, 1'b0, 8'd0, 10'd9, 1'b1, 1'b1, 2'd1});
    tbl.push_back('{20,   10'd20,   1'b0, 1'b0, 8'd0, 10'd0, 1'b0, 1'b0, 2'd2});
    tbl.push_back('{30,   10'd30,   1'b0, 1'b0, 8'd0, 10'd0, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{40,   10'd40,   1'b0, 1'b0, 8'd0, 10'd0, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{45,   10'd45,   1'b0, 1'b0, 8'd0, 10'd5, 1'b0, 1'b1, 2'd3});
    tbl.push_back('{511,  10'd511,  1'b0, 1'b0, 8'd0, 10'd1, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{512,  10'd512,  1'b0, 1'b1, 8'd0, 10'd2, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1022, 10'd1022, 1'b0, 1'b1, 8'd0, 10'd2, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1023, 10'd1023, 1'b1, 1'b1, 8'd0, 10'd3, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1024, 10'd0,    1'b0, 1'b0, 8'd1, 10'd4, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1025, 10'd1,    1'b0, 1'b0, 8'd1, 10'd5, 1'b0, 1'b1, 2'd3});
    tbl.push_back('{2047, 10'd1023, 1'b1, 1'b1, 8'd1, 10'd7, 1'b0, 1'b1, 2'd3});
    tbl.push_back('{2048, 10'd0,    1'b0, 1'b0, 8'd2, 10'd8, 1'b0, 1'b1, 2'd3});

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge sclk);
    chk_a("reset", 10'd0, 1'b0, 1'b0, 8'd0);
    chk_b("reset", 10'd0, 1'b0, 1'b0, 2'd0);

    // Release between edges at 200.1 ns; the 190 ns edge was the last reset edge.
    #160.1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    cur = 0;
    foreach (tbl[i]) begin
      while (cur < tbl[i].k) begin
        tick(1);
        cur++;
      end
      chk_a($sformatf("k=%0d", tbl[i].k), tbl[i].a_cnt, tbl[i].a_tc, tbl[i].a_half, tbl[i].a_wrap);
      chk_b($sformatf("k=%0d", tbl[i].k), tbl[i].b_cnt, tbl[i].b_tc, tbl[i].b_half, tbl[i].b_wrap);
    end

    // Mid-count reset of A at cnt=300, held for two edges.
    tick(300);
    chk_a("pre-midrst", 10'd300, 1'b0, 1'b0, 8'd2);
    rst_a = 1'b1;
    tick(1);
    chk_a("midrst e1", 10'd0, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk_a("midrst e2", 10'd0, 1'b0, 1'b0, 8'd0);
    rst_a = 1'b0;
    tick(1);
    chk_a("resume 1", 10'd1, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk_a("resume 2", 10'd2, 1'b0, 1'b0, 8'd0);

    // Reset coincident with terminal count on A.
    tick(1021);
    chk_a("pre-tcrst", 10'd1023, 1'b1, 1'b1, 8'd0);
    rst_a = 1'b1;
    tick(1);
    chk_a("tcrst", 10'd0, 1'b0, 1'b0, 8'd0);
    rst_a = 1'b0;
    tick(1);
    chk_a("post-tcrst", 10'd1, 1'b0, 1'b0, 8'd0);

    // Reset coincident with terminal count on B.
    rst_b = 1'b1;
    tick(1);
    chk_b("b rst", 10'd0, 1'b0, 1'b0, 2'd0);
    rst_b = 1'b0;
    tick(9);
    chk_b("b pre-tcrst", 10'd9, 1'b1, 1'b1, 2'd0);
    rst_b = 1'b1;
    tick(1);
    chk_b("b tcrst", 10'd0, 1'b0, 1'b0, 2'd0);
    rst_b = 1'b0;
    tick(10);
    chk_b("b one wrap", 10'd0, 1'b0, 1'b0, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_cnt.md
Name: ex_cnt

Overview:
Free-running, parameterised up-counter clocked by the system sample clock `sclk`. It is used as a basic timebase / cycle counter. It provides:
- the running count;
- a terminal-count strobe;
- a half-period flag;
- a saturating wrap counter for coarse extended timing.

No inputs other than clock and reset: the block counts unconditionally while out of reset.

Parameters:
- WIDTH, 10, bit width of `cnt`; legal range 2..32.
- MAX_VAL, 1023 (2^WIDTH-1), terminal value; `cnt` wraps to 0 after this value; legal range 1..2^WIDTH-1.
- WRAP_W, 8, bit width of `wrap_cnt`.

Ports:
- sclk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high. Sampled on the sclk rising edge.
- cnt  output  WIDTH  running count value (registered).
- cnt_tc  output  1  high while `cnt == MAX_VAL` (registered, single-cycle per period).
- cnt_half  output  1  high while `cnt > MAX_VAL/2` (integer divide), registered.
- wrap_cnt  output  WRAP_W  number of completed wraps since reset; saturates at all-ones.

Interface note: one clock (`sclk`); reset `rst` is synchronous and active-high. The block has no asynchronous reset path.

Behaviour:
- Reset: on any sclk rising edge with `rst`=1, the following are forced on that edge regardless of current state, including reset asserted mid-count:
  - `cnt` = 0;
  - `cnt_tc` = 0 (1 if MAX_VAL==0 is not legal, so always 0);
  - `cnt_half` = 0;
  - `wrap_cnt` = 0.
- Counting: on each rising edge with `rst`=0:
  - if `cnt == MAX_VAL`, then `cnt` ← 0;
  - otherwise `cnt` ← `cnt` + 1.
- Latency: the first edge after reset deassertion makes `cnt` = 1. `cnt` = 0 is held through the reset cycles and for one cycle after.
- Period: exactly MAX_VAL+1 cycles. Sequence: 0,1,…,MAX_VAL,0,…
- `cnt_tc`:
  - registered, so that it is high in exactly the cycle where `cnt` reads MAX_VAL;
  - computed from the next-count value, not delayed a cycle relative to `cnt`;
  - low otherwise.
- `cnt_half`: registered from the next-count value; high exactly in cycles where `cnt` > MAX_VAL/2.
- `wrap_cnt`:
  - increments on the edge where `cnt` goes MAX_VAL→0;
  - holds at 2^WRAP_W-1 once reached (no wrap);
  - unchanged otherwise.
- Arithmetic: unsigned, modulo-free by construction (never exceeds MAX_VAL). No X propagation: all registers are reset.
- Reset released between edges: has no effect until the next rising edge samples `rst`=0.
- Simultaneous terminal count and reset: reset wins. `wrap_cnt` is not incremented.

Test Plan:
- 20 ns sclk; `rst`=1 for 0–200.1 ns, then 0 -> `cnt`=0 through the last reset-sampled edge (190 ns). `cnt`=1 after the 210 ns edge, and increments by 1 every 20 ns.
- Free run past terminal:
  - `cnt` reaches 1023 -> `cnt_tc`=1 for exactly that cycle;
  - next edge `cnt`=0, `wrap_cnt`=1, `cnt_tc`=0.
- Half flag: with defaults, `cnt_half`=0 for `cnt` 0..511 and =1 for `cnt` 512..1023. It drops on the wrap to 0.
- Reset mid-count: assert `rst` at `cnt`=300 for 2 cycles -> all outputs 0 on the first sampled edge. Counting resumes 0,1,2… after release, and `wrap_cnt` stays 0.
- Parameter override MAX_VAL=9, WRAP_W=2 -> period 10 cycles (0..9). `wrap_cnt` counts 1,2,3 then stays 3 on subsequent wraps.
- Reset coincident with `cnt`=MAX_VAL -> `cnt`=0 and `wrap_cnt` not incremented.
